// File: rtl/vinsn_scoreboard_pkg.sv
// Purpose : shared types and sizing for the vector-instruction hazard scoreboard.
// Contents: table geometry, vreg mask / insn id types, table entry struct and
//           the stall-cause encoding reported on stall_cause_o.
package vinsn_scoreboard_pkg;

    localparam int unsigned NrInflight = 4;
    localparam int unsigned NrVReg     = 32;
    localparam int unsigned IdWidth    = 3;
    localparam int unsigned CntWidth   = $clog2(NrInflight + 1);
    localparam int unsigned IdxWidth   = (NrInflight > 1) ? $clog2(NrInflight) : 1;

    typedef logic [NrVReg-1:0]   vreg_mask_t;
    typedef logic [IdWidth-1:0]  insn_id_t;
    typedef logic [CntWidth-1:0] sb_cnt_t;
    typedef logic [IdxWidth-1:0] sb_idx_t;

    typedef struct packed {
        logic       valid;
        insn_id_t   id;
        vreg_mask_t rd;
        vreg_mask_t wr;
    } sb_entry_t;

    typedef enum logic [2:0] {
        STALL_NONE  = 3'd0,
        STALL_FULL  = 3'd1,
        STALL_DUPID = 3'd2,
        STALL_RAW   = 3'd3,
        STALL_WAW   = 3'd4,
        STALL_WAR   = 3'd5
    } sb_stall_e;

endpackage

// File: rtl/vinsn_scoreboard_if.sv
// Purpose : issue / launch / completion handshake between decoder, scoreboard,
//           launcher and committer.
// Signals : issue_valid/issue_ready/issue_id/issue_rd_mask/issue_wr_mask (decoder side),
//           launch_valid/launch_ready (launcher side), done_valid/done_id (committer).
// Modports: master = environment driving insns, slave = the scoreboard.
interface vinsn_scoreboard_if;
    import vinsn_scoreboard_pkg::*;

    logic       issue_valid;
    logic       issue_ready;
    insn_id_t   issue_id;
    vreg_mask_t issue_rd_mask;
    vreg_mask_t issue_wr_mask;
    logic       launch_valid;
    logic       launch_ready;
    logic       done_valid;
    insn_id_t   done_id;

    modport master (
        output issue_valid, issue_id, issue_rd_mask, issue_wr_mask,
        output launch_ready, done_valid, done_id,
        input  issue_ready, launch_valid
    );

    modport slave (
        input  issue_valid, issue_id, issue_rd_mask, issue_wr_mask,
        input  launch_ready, done_valid, done_id,
        output issue_ready, launch_valid
    );

endinterface

// File: rtl/vinsn_scoreboard_sb_free_finder.sv
// Purpose : priority encoder returning the lowest-numbered free table slot.
// Ports   : valid_i    - per-slot valid bits
//           free_idx_o - lowest index with valid_i==0 (0 when none free)
//           any_free_o - at least one slot free
module sb_free_finder
    import vinsn_scoreboard_pkg::*;
(
    input  logic [NrInflight-1:0] valid_i,
    output sb_idx_t               free_idx_o,
    output logic                  any_free_o
);

    // Scan high-to-low so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = NrInflight - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_idx_o = sb_idx_t'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vinsn_scoreboard.sv
// Purpose : register-level RAW/WAW/WAR hazard scoreboard allowing up to NrInflight
//           concurrent vector insns between decoder and launcher.
// Ports   : clk_i, rst_ni     - clock, async active-low reset
//           sb_if (slave)     - issue / launch / done handshake
//           flush_i           - drop every in-flight entry
//           inflight_cnt_o    - number of valid entries
//           full_o / empty_o  - table occupancy flags
//           stall_cause_o     - why the presented insn is blocked (sb_stall_e)
//           err_o             - sticky: a done id matched no valid entry
module vinsn_scoreboard
    import vinsn_scoreboard_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    vinsn_scoreboard_if.slave        sb_if,
    input  logic                     flush_i,
    output logic [CntWidth-1:0]      inflight_cnt_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [2:0]               stall_cause_o,
    output logic                     err_o
);

    sb_entry_t             table_q [NrInflight];
    sb_cnt_t               cnt_q;
    logic                  err_q;

    logic [NrInflight-1:0] valid_vec;
    logic [NrInflight-1:0] id_hit;
    logic [NrInflight-1:0] done_hit;
    vreg_mask_t            rd_union;
    vreg_mask_t            wr_union;
    sb_idx_t               free_idx;
    logic                  any_free;
    logic                  raw, waw, war, dup_id, block;
    logic                  alloc, retire;
    sb_stall_e             stall_cause;

    // Hazards look only at the registered table; a same-cycle retire or flush
    // does not unblock an issue until the following cycle.
    always_comb begin
        valid_vec = '0;
        id_hit    = '0;
        done_hit  = '0;
        rd_union  = '0;
        wr_union  = '0;
        for (int i = 0; i < NrInflight; i++) begin
            valid_vec[i] = table_q[i].valid;
            if (table_q[i].valid) begin
                rd_union    = rd_union | table_q[i].rd;
                wr_union    = wr_union | table_q[i].wr;
                id_hit[i]   = (table_q[i].id == sb_if.issue_id);
                done_hit[i] = (table_q[i].id == sb_if.done_id);
            end
        end
    end

    sb_free_finder u_free_finder (
        .valid_i    (valid_vec),
        .free_idx_o (free_idx),
        .any_free_o (any_free)
    );

    assign raw    = |(sb_if.issue_rd_mask & wr_union);
    assign waw    = |(sb_if.issue_wr_mask & wr_union);
    assign war    = |(sb_if.issue_wr_mask & rd_union);
    assign dup_id = |id_hit;

    assign full_o  = ~any_free;
    assign empty_o = ~|valid_vec;
    assign block   = full_o | dup_id | raw | waw | war | flush_i;

    assign sb_if.launch_valid = sb_if.issue_valid & ~block;
    assign sb_if.issue_ready  = sb_if.launch_ready & ~block;

    // issue_ready already excludes a full table, so free_idx is always a real slot.
    assign alloc  = sb_if.issue_valid & sb_if.issue_ready;
    assign retire = sb_if.done_valid & (|done_hit) & ~flush_i;

    always_comb begin
        stall_cause = STALL_NONE;
        if (sb_if.issue_valid && block && !flush_i) begin
            if (full_o)      stall_cause = STALL_FULL;
            else if (dup_id) stall_cause = STALL_DUPID;
            else if (raw)    stall_cause = STALL_RAW;
            else if (waw)    stall_cause = STALL_WAW;
            else             stall_cause = STALL_WAR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrInflight; i++) table_q[i] <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < NrInflight; i++) table_q[i].valid <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            // A retiring slot is valid, the allocated slot is free: never the same index.
            for (int i = 0; i < NrInflight; i++) begin
                if (sb_if.done_valid && done_hit[i]) table_q[i].valid <= 1'b0;
            end
            if (alloc) begin
                table_q[free_idx] <= '{valid: 1'b1,
                                       id:    sb_if.issue_id,
                                       rd:    sb_if.issue_rd_mask,
                                       wr:    sb_if.issue_wr_mask};
            end
            cnt_q <= cnt_q + sb_cnt_t'(alloc) - sb_cnt_t'(retire);
            if (sb_if.done_valid && !(|done_hit)) err_q <= 1'b1;
        end
    end

    assign inflight_cnt_o = cnt_q;
    assign err_o          = err_q;
    assign stall_cause_o  = stall_cause;

endmodule
